// File: rtl/uart_pkg.sv
// Shared types and helpers for the serial frame transmitter.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

   function automatic int frame_cycles(input int cpb, input int dbits,
                                       input int par_en, input int stop_bits);
      return (1 + dbits + par_en + stop_bits) * cpb;
   endfunction

   // Callers zero-extend narrower data; zeros do not change the XOR.
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period tick counter: runs 0..CLKS_PER_BIT-1, flags the last tick and wraps.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic last_tick_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign last_tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || last_tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_frame.sv
// Start/data/parity/stop frame transmitter with valid/ready byte intake.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   uart_state_t          state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [BW-1:0]        bit_q;
   logic                 par_q, tx_q;
   logic                 last_tick, last_stop, take;

   // Counter sits at zero while idle so a new frame starts on a fresh bit period.
   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (state_q == IDLE),
      .last_tick_o(last_tick)
   );

   assign last_stop = (state_q == STOP) && last_tick && (bit_q == LAST_STOP);
   assign ready     = (state_q == IDLE) || last_stop;
   assign take      = valid && ready;
   assign tx        = tx_q;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
      end else if (take) begin
         state_q <= START;
         tx_q    <= 1'b0;
         bit_q   <= '0;
         shift_q <= data;
         par_q   <= parity_bit(8'(data), PARITY_ODD != 0);
      end else if (last_tick) begin
         case (state_q)
            START: begin
               state_q <= DATA;
               tx_q    <= shift_q[0];
               bit_q   <= '0;
            end
            DATA: begin
               if (bit_q == LAST_DATA) begin
                  bit_q <= '0;
                  if (PARITY_EN != 0) begin
                     state_q <= PARITY;
                     tx_q    <= par_q;
                  end else begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end
               end else begin
                  bit_q   <= bit_q + 1'b1;
                  shift_q <= shift_q >> 1;
                  tx_q    <= shift_q[1];
               end
            end
            PARITY: begin
               state_q <= STOP;
               tx_q    <= 1'b1;
               bit_q   <= '0;
            end
            STOP: begin
               if (bit_q == LAST_STOP) state_q <= IDLE;
               else                    bit_q   <= bit_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
